// File: rtl/rv_mem_pkg.sv
// Shared definitions for the instruction/data memory arbiter: FSM states,
// access size codes and read/write encoding.
package rv_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } arb_state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Wait-cycle counter for an outstanding memory access; flags expiry once
// TIMEOUT cycles have elapsed without completion.
module mem_arb_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] count_r;

  // Saturating wait counter, restarted on every grant.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && (count_r != LIMIT)) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single shared memory port, with
// data priority bounded by a starvation limit and a per-access timeout.
module mem_arbiter
  import rv_mem_pkg::*;
#(
  parameter int TIMEOUT      = 16,
  parameter int STARVE_LIMIT = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_e    state_r;
  arb_state_e    state_nxt_s;
  logic [SW-1:0] starve_r;
  logic          grant_i_s;
  logic          grant_d_s;
  logic          busy_s;
  logic          expired_s;
  logic          done_s;

  assign busy_s = (state_r != ST_IDLE);
  assign done_s = busy_s && (mem_ack || expired_s);

  // Grant selection: data first, unless fetch has waited out its limit.
  always_comb begin
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    if (state_r == ST_IDLE) begin
      if (d_req && !(i_req && (starve_r == STARVE_MAX))) begin
        grant_d_s = 1'b1;
      end else if (i_req) begin
        grant_i_s = 1'b1;
      end else begin
        grant_d_s = 1'b0;
      end
    end else begin
      grant_i_s = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_d_s) begin
          state_nxt_s = ST_BUSY_D;
        end else if (grant_i_s) begin
          state_nxt_s = ST_BUSY_I;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (mem_ack || expired_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register and memory command latch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      mem_req   <= 1'b0;
      mem_rw    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_size  <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      if (grant_d_s) begin
        mem_req   <= 1'b1;
        mem_rw    <= d_rw;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        mem_size  <= d_size;
      end else if (grant_i_s) begin
        mem_req   <= 1'b1;
        mem_rw    <= RW_READ;
        mem_addr  <= i_addr;
        mem_wdata <= 32'd0;
        mem_size  <= SIZE_W;
      end else if (done_s) begin
        mem_req <= 1'b0;
      end else begin
        mem_req <= mem_req;
      end
    end
  end

  // Starvation counter: counts data grants that bypassed a waiting fetch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_r <= '0;
    end else if (grant_i_s) begin
      starve_r <= '0;
    end else if (grant_d_s && i_req && (starve_r != STARVE_MAX)) begin
      starve_r <= starve_r + SW'(1);
    end else begin
      starve_r <= starve_r;
    end
  end

  mem_arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (grant_i_s || grant_d_s),
    .enable (busy_s && !mem_ack),
    .expired(expired_s)
  );

  // Completion pulses follow mem_ack in the same cycle so read data needs no extra stage.
  assign i_ack   = (state_r == ST_BUSY_I) && mem_ack;
  assign d_ack   = (state_r == ST_BUSY_D) && mem_ack;
  assign i_err   = (state_r == ST_BUSY_I) && !mem_ack && expired_s;
  assign d_err   = (state_r == ST_BUSY_D) && !mem_ack && expired_s;
  assign i_rdata = i_ack ? mem_rdata : 32'd0;
  assign d_rdata = d_ack ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;

  localparam int TIMEOUT      = 16;
  localparam int STARVE_LIMIT = 2;
  localparam int OWN_NONE     = 0;
  localparam int OWN_I        = 1;
  localparam int OWN_D        = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_rw, mem_ack;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [1:0]  d_size;
  logic        i_ack, d_ack, i_err, d_err, mem_req, mem_rw;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [1:0]  mem_size;

  mem_arbiter #(.TIMEOUT(TIMEOUT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: who owns the memory port, how long it has waited, starvation count.
  int          m_owner = OWN_NONE;
  int          m_age   = 0;
  int          m_starve = 0;
  int          ack_delay = 0;
  logic        m_rw;
  logic [31:0] m_addr, m_wdata;
  logic [1:0]  m_size;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner  = OWN_NONE;
    m_age    = 0;
    m_starve = 0;
  endtask

  task automatic pick_delay();
    if ($urandom_range(0, 3) == 0) ack_delay = $urandom_range(TIMEOUT - 1, TIMEOUT + 3);
    else ack_delay = $urandom_range(0, 3);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"},   32'(mem_req),  32'd0);
    chk({tag, "_mem_rw"},    32'(mem_rw),   32'd0);
    chk({tag, "_mem_addr"},  mem_addr,      32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata,     32'd0);
    chk({tag, "_mem_size"},  32'(mem_size), 32'd0);
    chk({tag, "_acks"},      32'({i_ack, d_ack, i_err, d_err}), 32'd0);
  endtask

  // One clock cycle: inputs are already set; compare outputs, advance model, cross the edge.
  task automatic cycle();
    logic        ea_i, ea_d, ee_i, ee_d;
    logic [31:0] ed_i, ed_d;
    int          drop;
    drop = OWN_NONE;
    #2;
    ea_i = (m_owner == OWN_I) && mem_ack;
    ea_d = (m_owner == OWN_D) && mem_ack;
    ee_i = (m_owner == OWN_I) && !mem_ack && (m_age == TIMEOUT);
    ee_d = (m_owner == OWN_D) && !mem_ack && (m_age == TIMEOUT);
    ed_i = ea_i ? mem_rdata : 32'd0;
    ed_d = ea_d ? mem_rdata : 32'd0;
    chk("mem_req", 32'(mem_req), 32'(m_owner != OWN_NONE));
    if (m_owner != OWN_NONE) begin
      chk("mem_rw",   32'(mem_rw),   32'(m_rw));
      chk("mem_addr", mem_addr,      m_addr);
      chk("mem_size", 32'(mem_size), 32'(m_size));
      if (m_owner == OWN_D) chk("mem_wdata", mem_wdata, m_wdata);
    end
    chk("i_ack",   32'(i_ack), 32'(ea_i));
    chk("d_ack",   32'(d_ack), 32'(ea_d));
    chk("i_err",   32'(i_err), 32'(ee_i));
    chk("d_err",   32'(d_err), 32'(ee_d));
    chk("i_rdata", i_rdata, ed_i);
    chk("d_rdata", d_rdata, ed_d);
    if (m_owner != OWN_NONE) begin
      if (mem_ack || (m_age == TIMEOUT)) begin
        drop    = m_owner;
        m_owner = OWN_NONE;
      end else begin
        m_age++;
      end
    end else if (d_req && !(i_req && (m_starve == STARVE_LIMIT))) begin
      m_owner = OWN_D; m_age = 0;
      m_rw = d_rw; m_addr = d_addr; m_wdata = d_wdata; m_size = d_size;
      if (i_req && (m_starve < STARVE_LIMIT)) m_starve++;
      pick_delay();
    end else if (i_req) begin
      m_owner = OWN_I; m_age = 0;
      m_rw = 1'b0; m_addr = i_addr; m_size = 2'd2;
      m_starve = 0;
      pick_delay();
    end
    @(posedge clock);
    #1;
    if (drop == OWN_I) i_req = 1'b0;
    if (drop == OWN_D) d_req = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && m_owner != OWN_NONE; k++) begin
      mem_ack = (m_age == 0);
      cycle();
    end
    mem_ack = 1'b0;
    chk("drain_done", 32'(m_owner), 32'(OWN_NONE));
    cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not complete, n_bad=%0d", n_bad);
    $fatal(1);
  end

  initial begin
    logic [7:0] order [6];
    string      exp_ord;
    int         ngr, rise, errc, ackc, acks, errs, saw;
    logic       prev_req, after_req;

    reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_rw = 1'b0; mem_ack = 1'b0;
    i_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0; d_size = 2'd0; mem_rdata = 32'd0;
    #3;
    chk_all_zero("reset");
    @(posedge clock); #1;

    // Single fetch, ack two cycles after mem_req, granted on first edge after release.
    reset = 1'b0;
    i_req = 1'b1; i_addr = 32'h0100_0000;
    #1 chk("pre_grant_mem_req", 32'(mem_req), 32'd0);
    cycle();
    #1;
    chk("fetch_mem_req",  32'(mem_req),  32'd1);
    chk("fetch_mem_rw",   32'(mem_rw),   32'd0);
    chk("fetch_mem_size", 32'(mem_size), 32'd2);
    chk("fetch_mem_addr", mem_addr,      32'h0100_0000);
    cycle();
    cycle();
    mem_ack = 1'b1; mem_rdata = 32'h0000_0013;
    #1;
    chk("fetch_i_ack",   32'(i_ack), 32'd1);
    chk("fetch_i_rdata", i_rdata,    32'h0000_0013);
    cycle();
    mem_ack = 1'b0;
    #1;
    chk("fetch_gap_mem_req", 32'(mem_req), 32'd0);
    chk("fetch_gap_i_rdata", i_rdata,      32'd0);
    cycle();

    // Both requesters continuously active: grant order must be D,D,I,D,D,I.
    exp_ord = "DDIDDI";
    d_rw = 1'b1; d_addr = 32'h0000_2000; d_wdata = 32'h1234_5678; d_size = 2'd2;
    i_addr = 32'h0000_1000;
    ngr = 0;
    prev_req = mem_req;
    for (int k = 0; k < 60 && ngr < 6; k++) begin
      i_req = 1'b1; d_req = 1'b1;
      mem_ack = (m_owner != OWN_NONE) && (m_age == 1);
      #1;
      if (mem_req && !prev_req) begin
        order[ngr] = (mem_addr == 32'h0000_2000) ? 8'h44 : 8'h49;
        ngr++;
      end
      prev_req = mem_req;
      cycle();
    end
    chk("grant_count", 32'(ngr), 32'd6);
    for (int k = 0; k < 6; k++) chk($sformatf("grant_order_%0d", k), 32'(order[k]), 32'(exp_ord[k]));
    if (m_owner == OWN_I) d_req = 1'b0;
    else if (m_owner == OWN_D) i_req = 1'b0;
    else begin i_req = 1'b0; d_req = 1'b0; end
    drain();
    i_req = 1'b0; d_req = 1'b0;
    cycle();

    // Data write with no memory response: error 16 cycles after mem_req rises.
    d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h0100_0100; d_wdata = 32'hDEAD_BEEF; d_size = 2'd0;
    rise = -1; errc = -1; acks = 0; after_req = 1'b1;
    for (int k = 0; k < 40; k++) begin
      mem_ack = 1'b0;
      #1;
      if (mem_req && rise < 0) begin
        rise = k;
        chk("to_mem_wdata", mem_wdata,     32'hDEAD_BEEF);
        chk("to_mem_size",  32'(mem_size), 32'd0);
        chk("to_mem_rw",    32'(mem_rw),   32'd1);
      end
      if (d_err && errc < 0) errc = k;
      if (d_ack) acks++;
      if (errc >= 0 && k == errc + 1) after_req = mem_req;
      cycle();
      if (errc >= 0 && k > errc) break;
    end
    chk("timeout_latency", 32'(errc - rise), 32'd16);
    chk("timeout_no_ack",  32'(acks), 32'd0);
    chk("timeout_idle",    32'(after_req), 32'd0);

    // mem_ack arriving exactly on the timeout cycle completes normally.
    d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h0100_0200; d_size = 2'd2;
    rise = -1; ackc = -1; errs = 0;
    for (int k = 0; k < 40; k++) begin
      mem_ack = (rise >= 0) && (k == rise + 16);
      mem_rdata = 32'hCAFE_0001;
      #1;
      if (mem_req && rise < 0) rise = k;
      if (d_ack && ackc < 0) begin
        ackc = k;
        chk("edge_d_rdata", d_rdata, 32'hCAFE_0001);
      end
      if (d_err) errs++;
      cycle();
      if (ackc >= 0) break;
    end
    mem_ack = 1'b0;
    chk("edge_ack_cycle", 32'(ackc - rise), 32'd16);
    chk("edge_no_err",    32'(errs), 32'd0);
    cycle();

    // Reset in the middle of a data access: silent drop, then normal fetch.
    d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h0100_0300; d_wdata = 32'h5555_AAAA; d_size = 2'd1;
    cycle(); cycle(); cycle();
    reset = 1'b1; mem_ack = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    model_reset();
    d_req = 1'b0;
    @(posedge clock); #1;
    chk_all_zero("held_reset");
    mem_ack = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    #1;
    chk("post_reset_acks", 32'({i_ack, d_ack, i_err, d_err}), 32'd0);
    cycle();
    mem_ack = 1'b0;
    cycle();
    i_req = 1'b1; i_addr = 32'h0100_0400;
    saw = 0;
    for (int k = 0; k < 10 && saw == 0; k++) begin
      mem_ack = (m_owner == OWN_I);
      mem_rdata = 32'h0000_0093;
      #1;
      if (i_ack) saw = 1;
      cycle();
    end
    mem_ack = 1'b0;
    chk("post_reset_fetch", 32'(saw), 32'd1);
    cycle();

    // Randomized traffic with random latencies, timeouts and stray acks.
    for (int k = 0; k < 3000; k++) begin
      if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req = 1'b1; i_addr = $urandom;
      end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_rw = 1'($urandom_range(0, 1)); d_addr = $urandom;
        d_wdata = $urandom; d_size = 2'($urandom_range(0, 2));
      end
      mem_rdata = $urandom;
      if (m_owner != OWN_NONE) mem_ack = (m_age == ack_delay);
      else mem_ack = ($urandom_range(0, 7) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16, is the maximum cycles a granted access waits for mem_ack before abort.
REQ-002 Parameter STARVE_LIMIT, default 2, is the maximum consecutive data grants while an instruction request waits.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 i_req  input  1  fetch request; held high until i_ack or i_err.
REQ-006 i_addr  input  32  fetch address; held stable while i_req is high.
REQ-007 i_ack  output  1  one-cycle pulse: fetch complete, i_rdata valid this cycle.
REQ-008 i_rdata  output  32  fetch read data.
REQ-009 d_req  input  1  data request; held high until d_ack or d_err.
REQ-010 d_rw  input  1  0 = read, 1 = write.
REQ-011 d_addr  input  32  data address.
REQ-012 d_wdata  input  32  store data.
REQ-013 d_size  input  2  access size: 0 byte, 1 half, 2 word.
REQ-014 d_ack  output  1  one-cycle pulse: data access complete, d_rdata valid for reads.
REQ-015 d_rdata  output  32  load data.
REQ-016 i_err, d_err  output  1 each  one-cycle pulse: access aborted by timeout.
REQ-017 mem_req  output  1  request to shared memory, registered.
REQ-018 mem_rw, mem_addr, mem_wdata, mem_size  output  1/32/32/2  registered memory command; instruction grants drive rw=0, size=2.
REQ-019 mem_ack  input  1  memory completion pulse; mem_rdata valid in that cycle.
REQ-020 mem_rdata  input  32  memory read data.

Function
REQ-021 FSM states IDLE, BUSY_I, BUSY_D; exactly one state at a time.
REQ-022 IDLE with any request: grant on the same edge, latch command into mem_* registers, set mem_req=1 in the following cycle.
REQ-023 Both requests in IDLE: data wins unless starve count equals STARVE_LIMIT, in which case instruction wins.
REQ-024 Starve counter increments on each data grant made while i_req is high, clears on any instruction grant, saturates at STARVE_LIMIT.
REQ-025 In BUSY_x, mem_ack high: pulse x_ack, drive x_rdata = mem_rdata combinationally that cycle, drop mem_req on the next edge, return to IDLE.
REQ-026 Minimum spacing: a new grant is made no earlier than the edge after an ack cycle; mem_req is low for at least one cycle between accesses.
REQ-027 Wait counter clears on grant and increments each BUSY cycle without mem_ack; on reaching TIMEOUT, pulse x_err, drop mem_req, return to IDLE, no x_ack.
REQ-028 mem_ack in IDLE is ignored; no ack or err pulse results.
REQ-029 mem_ack on the same cycle the wait counter reaches TIMEOUT: ack wins, no err.
REQ-030 Requests are not retracted; requester deassertion in BUSY is ignored until completion.
REQ-031 i_rdata and d_rdata read 0 in any cycle where the corresponding ack is low.

Reset
REQ-032 Reset asserted drives state IDLE, starve and wait counters 0, and mem_req, mem_rw, mem_addr, mem_wdata, mem_size, i_ack, d_ack, i_err, d_err all 0, immediately and independent of clock.
REQ-033 Reset during BUSY drops the outstanding access silently; no ack or err pulse is generated for it after reset release.
REQ-034 The first grant is possible on the first rising edge after reset deasserts.

Structure
REQ-035 Shared package rv_mem_pkg holds the FSM state enum, access size constants (SIZE_B, SIZE_H, SIZE_W) and the rw encoding.
REQ-036 The wait counter and timeout compare are implemented in one sub-module, mem_arb_watchdog (inputs clear, enable; output expired).

Verification
REQ-037 i_req=1, i_addr=0x01000000, mem_ack 2 cycles after mem_req rises with mem_rdata=0x00000013 -> mem_req high 1 cycle after the request, i_ack pulse with i_rdata=0x00000013, mem_rw=0, mem_size=2.
REQ-038 i_req and d_req both high continuously, each with mem_ack 1 cycle after mem_req -> grant order D,D,I,D,D,I.
REQ-039 d_req write, d_addr=0x01000100, d_wdata=0xDEADBEEF, d_size=0, no mem_ack -> d_err pulse exactly 16 cycles after mem_req rises, no d_ack, FSM back to IDLE.
REQ-040 mem_ack on the exact timeout cycle -> d_ack pulses, d_err stays 0.
REQ-041 Reset asserted mid BUSY_D, mem_ack pulsed after release -> all outputs 0 during reset, no ack or err after release, next i_req served normally.
